// File: rtl/fp12_pkg.sv
// FP12 format definitions shared by the multiplier-side blocks.
// Layout is {sign, 5-bit exponent, 6-bit fraction}, exponent bias 15.
package fp12_pkg;

    localparam int unsigned FP12_W = 12;
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned FRAC_W = 6;
    localparam int unsigned BIAS   = 15;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp12_t;

    localparam logic [FP12_W-1:0] FP12_ONE = 12'h3C0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index after the pointer wins.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic               any_grant
);

    logic [PTR_W-1:0] idx;

    // Offset NUM_REQ wraps back to the pointer itself, so it is searched last.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = PTR_W'((32'(pointer) + off) % NUM_REQ);
            if (grant == '0 && eligible[idx]) begin
                grant[idx] = 1'b1;
            end
        end
    end

    assign any_grant = |grant;

endmodule

// File: rtl/fp12_mult_arbiter.sv
// Shares one pipelined FP12 multiplier between NUM_REQ requesters with round-robin issue,
// one-hot tag tracking and per-requester held response registers.
module fp12_mult_arbiter
    import fp12_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [FP12_W*NUM_REQ-1:0] req_a,
    input  logic [FP12_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [FP12_W*NUM_REQ-1:0] rsp_data,
    output logic [FP12_W-1:0]         mul_a,
    output logic [FP12_W-1:0]         mul_b,
    output logic                      mul_valid_in,
    input  logic [FP12_W-1:0]         mul_result,
    input  logic                      mul_valid_out,
    output logic                      err_orphan
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        busy_q, busy_d;
    logic [NUM_REQ-1:0]        eligible, grant, consume, tag_out;
    logic                      any_grant;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    fp12_t                     issue_a_q, issue_b_q;
    logic                      issue_v_q;
    logic [FP12_W-1:0]         sel_a, sel_b;
    logic [NUM_REQ-1:0]        tag_q [MUL_LAT+1];
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [FP12_W*NUM_REQ-1:0] rsp_data_q, rsp_data_d;
    logic                      err_q;

    assign eligible = req_valid & ~busy_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .eligible  (eligible),
        .pointer   (ptr_q),
        .grant     (grant),
        .any_grant (any_grant)
    );

    assign req_ready = grant;
    assign consume   = rsp_valid_q & rsp_ready;
    // The last tag stage lines up with mul_valid_out.
    assign tag_out   = tag_q[MUL_LAT];

    always_comb begin
        ptr_d = ptr_q;
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                ptr_d = PTR_W'(i);
                sel_a = req_a[FP12_W*i +: FP12_W];
                sel_b = req_b[FP12_W*i +: FP12_W];
            end
        end
    end

    // A requester cannot be granted and consume in the same cycle, so set/clear never collide.
    always_comb begin
        busy_d      = (busy_q | grant) & ~consume;
        rsp_valid_d = rsp_valid_q & ~consume;
        rsp_data_d  = rsp_data_q;
        if (mul_valid_out) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (tag_out[i]) begin
                    rsp_valid_d[i]                   = 1'b1;
                    rsp_data_d[FP12_W*i +: FP12_W] = mul_result;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            busy_q      <= '0;
            issue_a_q   <= '0;
            issue_b_q   <= '0;
            issue_v_q   <= 1'b0;
            for (int k = 0; k <= MUL_LAT; k++) begin
                tag_q[k] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            issue_v_q <= any_grant;
            if (any_grant) begin
                issue_a_q <= sel_a;
                issue_b_q <= sel_b;
            end
            tag_q[0] <= grant;
            for (int k = 1; k <= MUL_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            if (mul_valid_out && tag_out == '0) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mul_a        = issue_a_q;
    assign mul_b        = issue_b_q;
    assign mul_valid_in = issue_v_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign err_orphan   = err_q;

endmodule

// File: tb/tb_fp12_mult_arbiter.sv
// Bench for fp12_mult_arbiter with a one-cycle behavioural FP12 multiplier beside it.
module tb_fp12_mult_arbiter;

    localparam int N = 4;

    logic          clk, rst_n;
    logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [12*N-1:0] req_a, req_b, rsp_data;
    logic [11:0]   mul_a, mul_b, mul_result, res_q;
    logic          mul_valid_in, mul_valid_out, err_orphan, mv_q, force_mvo;

    typedef struct {
        int          idx;
        logic [11:0] data;
    } exp_t;

    exp_t sb[$];
    int   glog[$];
    int   hs_cnt[N];
    int   cyc, tests, fails;

    fp12_mult_arbiter #(.NUM_REQ(N), .MUL_LAT(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_valid_in  (mul_valid_in),
        .mul_result    (mul_result),
        .mul_valid_out (mul_valid_out),
        .err_orphan    (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating FP12 product; zero exponent treated as zero, overflow saturates.
    function automatic logic [11:0] mulf(input logic [11:0] a, input logic [11:0] b);
        logic        s;
        int          e;
        logic [13:0] p;
        logic [5:0]  f;
        s = a[11] ^ b[11];
        if (a[10:6] == 5'd0 || b[10:6] == 5'd0) return {s, 11'd0};
        p = {1'b1, a[5:0]} * {1'b1, b[5:0]};
        e = int'(a[10:6]) + int'(b[10:6]) - 15;
        if (p[13]) begin
            f = p[12:7];
            e = e + 1;
        end else begin
            f = p[11:6];
        end
        if (e <= 0) return {s, 11'd0};
        if (e >= 31) return {s, 5'd30, 6'h3F};
        return {s, e[4:0], f};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_q  <= 1'b0;
            res_q <= '0;
        end else begin
            mv_q  <= mul_valid_in;
            res_q <= mulf(mul_a, mul_b);
        end
    end
    assign mul_valid_out = mv_q | force_mvo;
    assign mul_result    = res_q;

    // Records handshakes, checks consumed responses against the scoreboard, advances a cycle.
    task automatic tick();
        bit found;
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                sb.push_back('{idx: i, data: mulf(req_a[12*i +: 12], req_b[12*i +: 12])});
                glog.push_back(i);
                hs_cnt[i]++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
                found = 1'b0;
                tests++;
                for (int k = 0; k < sb.size(); k++) begin
                    if (!found && sb[k].idx == i) begin
                        found = 1'b1;
                        if (rsp_data[12*i +: 12] !== sb[k].data) begin
                            fails++;
                            $display("FAIL sb_data req%0d: got %h want %h", i,
                                     rsp_data[12*i +: 12], sb[k].data);
                        end
                        sb.delete(k);
                    end
                end
                if (!found) begin
                    fails++;
                    $display("FAIL sb_unexpected req%0d: got %h want none", i,
                             rsp_data[12*i +: 12]);
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        force_mvo = 1'b0;
        sb.delete();
        glog.delete();
        for (int i = 0; i < N; i++) hs_cnt[i] = 0;
        cyc = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        force_mvo = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests += 7;
        if (req_ready !== 4'b0) begin fails++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
        if (rsp_valid !== 4'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b want 0000", rsp_valid); end
        if (rsp_data !== 48'b0) begin fails++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        if (mul_a !== 12'b0) begin fails++; $display("FAIL rst_mul_a: got %h want 0", mul_a); end
        if (mul_b !== 12'b0) begin fails++; $display("FAIL rst_mul_b: got %h want 0", mul_b); end
        if (mul_valid_in !== 1'b0) begin fails++; $display("FAIL rst_mul_valid_in: got %b want 0", mul_valid_in); end
        if (err_orphan !== 1'b0) begin fails++; $display("FAIL rst_err_orphan: got %b want 0", err_orphan); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int hs_cyc, got_cyc;
        reset_dut();
        req_a = '0;
        req_b = '0;
        req_a[24 +: 12] = 12'h3E0;
        req_b[24 +: 12] = 12'h3E0;
        req_valid = 4'b0100;
        hs_cyc  = cyc;
        tick();
        req_valid = '0;
        got_cyc = -1;
        for (int k = 0; k < 10 && got_cyc < 0; k++) begin
            if (rsp_valid[2]) got_cyc = cyc;
            else tick();
        end
        tests += 3;
        if (hs_cnt[2] !== 1) begin fails++; $display("FAIL single_hs: got %0d want 1", hs_cnt[2]); end
        if (got_cyc - hs_cyc !== 3) begin
            fails++; $display("FAIL single_latency: got %0d want 3", got_cyc - hs_cyc);
        end
        if (rsp_data[24 +: 12] !== 12'h408) begin
            fails++; $display("FAIL single_data: got %h want 408", rsp_data[24 +: 12]);
        end
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = '0;
    endtask

    task automatic test_round_robin();
        int bad;
        reset_dut();
        req_valid = '1;
        rsp_ready = '1;
        for (int k = 0; k < 20; k++) begin
            req_a = 48'({$urandom(), $urandom()});
            req_b = 48'({$urandom(), $urandom()});
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < 6; k++) tick();
        tests += 3;
        if (glog.size() !== 20) begin fails++; $display("FAIL rr_count: got %0d want 20", glog.size()); end
        bad = -1;
        for (int k = 0; k < glog.size(); k++) if (bad < 0 && glog[k] != k % N) bad = k;
        if (bad !== -1) begin fails++; $display("FAIL rr_order: got grant %0d at %0d want %0d", glog[bad], bad, bad % N); end
        if (sb.size() !== 0) begin fails++; $display("FAIL rr_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_hold();
        logic [11:0] held;
        bit          seen, changed;
        reset_dut();
        req_valid = '1;
        rsp_ready = 4'b1101;
        seen      = 1'b0;
        changed   = 1'b0;
        held      = '0;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid[1]) begin
                if (!seen) held = rsp_data[12 +: 12];
                else if (rsp_data[12 +: 12] !== held) changed = 1'b1;
                seen = 1'b1;
            end
            req_a = 48'({$urandom(), $urandom()});
            req_b = 48'({$urandom(), $urandom()});
            tick();
        end
        tests += 5;
        if (hs_cnt[1] !== 1) begin fails++; $display("FAIL hold_hs1: got %0d want 1", hs_cnt[1]); end
        if (!(seen && rsp_valid[1] === 1'b1)) begin fails++; $display("FAIL hold_valid: got %b want 1", rsp_valid[1]); end
        if (changed !== 1'b0) begin fails++; $display("FAIL hold_stable: got changed=%b want 0", changed); end
        if (hs_cnt[0] < 4 || hs_cnt[2] < 4 || hs_cnt[3] < 4) begin
            fails++; $display("FAIL hold_others: got %0d/%0d/%0d want >=4 each", hs_cnt[0], hs_cnt[2], hs_cnt[3]);
        end
        rsp_ready = '1;
        tick();
        req_valid = '0;
        for (int k = 0; k < 6; k++) tick();
        if (sb.size() !== 0) begin fails++; $display("FAIL hold_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_reeligible();
        reset_dut();
        req_a     = 48'h3C0_3C0_3C0_3E0;
        req_b     = 48'h400_400_400_440;
        req_valid = 4'b0001;
        tick();
        for (int k = 0; k < 10 && !rsp_valid[0]; k++) tick();
        rsp_ready = 4'b0001;
        #1;
        tests += 2;
        if (req_ready[0] !== 1'b0) begin fails++; $display("FAIL reelig_same_cycle: got %b want 0", req_ready[0]); end
        tick();
        rsp_ready = '0;
        #1;
        if (req_ready[0] !== 1'b1) begin fails++; $display("FAIL reelig_next_cycle: got %b want 1", req_ready[0]); end
        tick();
        req_valid = '0;
        rsp_ready = '1;
        for (int k = 0; k < 5; k++) tick();
        rsp_ready = '0;
    endtask

    task automatic test_reset_midflight();
        bit seen;
        reset_dut();
        req_valid = '1;
        rsp_ready = '0;
        for (int k = 0; k < 3; k++) tick();
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        tests += 5;
        if (rsp_valid !== 4'b0 || rsp_data !== 48'b0) begin
            fails++; $display("FAIL mid_rsp: got %b/%h want 0/0", rsp_valid, rsp_data);
        end
        if (mul_valid_in !== 1'b0 || mul_a !== 12'b0) begin
            fails++; $display("FAIL mid_issue: got %b/%h want 0/0", mul_valid_in, mul_a);
        end
        if (req_ready !== 4'b0) begin fails++; $display("FAIL mid_ready: got %b want 0000", req_ready); end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rsp_valid != 4'b0 || mul_valid_out) seen = 1'b1;
            tick();
        end
        if (seen !== 1'b0) begin fails++; $display("FAIL mid_stale: got activity=%b want 0", seen); end
        req_valid = '1;
        #1;
        if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_orphan();
        reset_dut();
        force_mvo = 1'b1;
        tick();
        force_mvo = 1'b0;
        tests += 4;
        if (err_orphan !== 1'b1) begin fails++; $display("FAIL orphan_set: got %b want 1", err_orphan); end
        if (rsp_valid !== 4'b0) begin fails++; $display("FAIL orphan_rsp: got %b want 0000", rsp_valid); end
        for (int k = 0; k < 5; k++) tick();
        if (err_orphan !== 1'b1) begin fails++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
        reset_dut();
        if (err_orphan !== 1'b0) begin fails++; $display("FAIL orphan_clear: got %b want 0", err_orphan); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_reeligible();
        test_reset_midflight();
        test_orphan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp12_mult_arbiter.md
# fp12_mult_arbiter

Round-robin arbiter that shares one pipelined FP12 multiplier (1 sign, 5 exponent, 6 fraction bits, bias 15) between NUM_REQ independent requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the multiplier. It tags each issued operation, then routes the multiplier result back to a per-requester response register held until the requester consumes it. It sits between compute lanes and the single multiplier instance, which is instantiated beside it and connected through the mul_* ports.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- MUL_LAT, 1: multiplier latency in cycles, from mul_valid_in sampled to mul_valid_out high.
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  NUM_REQ  operand pair valid, per requester.
- req_ready  output  NUM_REQ  one-hot grant, combinational; handshake = req_valid[i] & req_ready[i].
- req_a, req_b  input  12*NUM_REQ  packed operands; requester i at [12i+11:12i].
- rsp_valid  output  NUM_REQ  result held for requester i.
- rsp_ready  input  NUM_REQ  requester consumes result.
- rsp_data  output  12*NUM_REQ  packed results, same packing as req_a.
- mul_a, mul_b  output  12  registered operands to the multiplier.
- mul_valid_in  output  1  registered issue strobe.
- mul_result  input  12  multiplier result.
- mul_valid_out  input  1  multiplier result valid.
- err_orphan  output  1  sticky: mul_valid_out arrived with no tag in flight.

## Operation
- busy[i] is set on handshake of requester i. It clears at the clock edge where rsp_valid[i] & rsp_ready[i]. Each requester has at most one operation outstanding, so a response register never overflows.
- Eligible[i] = req_valid[i] & !busy[i], evaluated from registered state. A requester that consumes its response in cycle t is eligible again at t+1, never in t.
- Round-robin: the pointer holds the last granted index. The search starts at pointer+1 and wraps modulo NUM_REQ. The first eligible index gets req_ready. The pointer updates only on a grant.
- On a handshake, the issue register captures {req_a[i], req_b[i]} and mul_valid_in=1 for one cycle. A one-hot tag enters a MUL_LAT+1-deep tag shift register aligned with mul_valid_out.
- When mul_valid_out=1 and the aligned tag is nonzero: rsp_data[tag] <= mul_result and rsp_valid[tag] <= 1.
- The arbiter never inspects or alters operand/result bits. Zero, underflow and saturation are the multiplier's concern.
- When mul_valid_out=1 and the aligned tag is zero: set err_orphan. err_orphan clears only on reset.
- req_valid dropping without a handshake is legal; no state changes.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, mul_a=0, mul_b=0, mul_valid_in=0, err_orphan=0, busy=0, tags=0, pointer=NUM_REQ-1 (requester 0 has first priority).
- Handshake in cycle t gives mul_valid_in high in t+1, mul_valid_out in t+1+MUL_LAT, and rsp_valid[i] high in t+2+MUL_LAT. For MUL_LAT=1, handshake to response is 3 cycles.
- Throughput: one issue per cycle across requesters. A single requester gets one issue per MUL_LAT+3 cycles minimum, including the consume cycle.
- Simultaneous events:
  - Response write to requester j and consume by requester i≠j in the same cycle are independent.
  - Grant to requester i and result write to requester j are independent.
- rsp_valid[i] stays high, with rsp_data stable, until consumed.
- Reset mid-operation: all in-flight tags and held responses are discarded. The multiplier shares rst_n, so no stale mul_valid_out follows.

## Structure
- Shared package fp12_pkg: FP12_W=12, EXP_W=5, FRAC_W=6, BIAS=15, the fp12_t packed struct {sign, exp, frac}, and FP12_ONE=12'h3C0.
- Sub-module rr_pick, combinational: inputs eligible[NUM_REQ] and pointer; outputs one-hot grant and any_grant.
- Tag pipeline, busy flags and response registers stay in the top.

## Test plan
- Single request, 0x3E0×0x3E0 (1.5×1.5) from requester 2 → rsp_valid[2] high exactly 3 cycles after the handshake, rsp_data[2]=0x408 (2.25).
- All four req_valid held high continuously, each consuming immediately → grants in order 0,1,2,3,0,… with no index granted twice within 4 consecutive grants.
- Requester 1 holds rsp_ready=0 for 20 cycles with req_valid high → exactly one handshake; other requesters keep being granted every rotation; rsp_data[1] stays stable.
- Requester 0 consumes in cycle t with req_valid still high → req_ready[0]=0 in t, granted no earlier than t+1.
- rst_n pulsed low while 3 operations are in flight → all outputs return to reset values; no rsp_valid follows; the first grant after reset goes to requester 0.
- mul_valid_out forced high with no issue outstanding → err_orphan=1 next cycle, stays high until reset.
